// File: rtl/fetch_queue_if.sv
// Fetch-unit bus bundle: redirect, instruction-memory request/response and decode handshake.
// Signal directions are named from the fetch unit's point of view.
interface fetch_queue_if #(
  parameter int PC_BITS    = 16,
  parameter int INSTR_BITS = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  redirect_i;
  logic [PC_BITS-1:0]    redirect_pc_i;
  logic                  imem_req_o;
  logic [PC_BITS-1:0]    imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [INSTR_BITS-1:0] imem_rdata_i;
  logic                  instr_valid_o;
  logic [INSTR_BITS-1:0] instr_o;
  logic [PC_BITS-1:0]    pc_o;
  logic                  instr_ready_i;
  logic [CNT_W-1:0]      count_o;

  // The fetch unit masters the memory request side.
  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, count_o
  );

  // Environment: memory, decode and branch unit.
  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Sequential-PC instruction fetch with credit-limited pipelined memory requests and a
// DEPTH-entry instruction queue; a redirect flushes the queue and drops in-flight responses.
module fetch_queue #(
  parameter int                 PC_BITS    = 16,
  parameter int                 INSTR_BITS = 32,
  parameter int                 DEPTH      = 4,
  parameter int                 PC_STEP    = 4,
  parameter logic [PC_BITS-1:0] RESET_PC   = '0
) (
  input logic           clk_i,
  input logic           rst_i,
  fetch_queue_if.master bus
);
  localparam int                 PTR_W = $clog2(DEPTH);
  localparam int                 CNT_W = PTR_W + 1;
  localparam logic [PC_BITS-1:0] STEP  = PC_BITS'(PC_STEP);

  logic [PC_BITS-1:0]    r_fetch_pc;
  logic [PC_BITS-1:0]    r_resp_pc;
  logic [CNT_W-1:0]      r_inflight;
  logic [CNT_W-1:0]      r_drop;
  logic [CNT_W-1:0]      r_count;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [INSTR_BITS-1:0] r_instr_mem [DEPTH];
  logic [PC_BITS-1:0]    r_pc_mem    [DEPTH];

  logic [CNT_W:0] w_credit_used;
  logic           w_req;
  logic           w_issue;
  logic           w_resp;
  logic           w_drop_resp;
  logic           w_push;
  logic           w_valid;
  logic           w_pop;

  // Outstanding plus buffered instructions may never exceed the queue size.
  assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req         = !rst_i && !bus.redirect_i && (w_credit_used < (CNT_W+1)'(DEPTH));
  assign w_issue       = w_req && bus.imem_gnt_i;
  assign w_resp        = bus.imem_rvalid_i && (r_inflight != '0);
  assign w_drop_resp   = w_resp && (r_drop != '0);
  assign w_push        = !rst_i && !bus.redirect_i && w_resp && !w_drop_resp;
  assign w_valid       = (r_count != '0) && !bus.redirect_i;
  assign w_pop         = w_valid && bus.instr_ready_i;

  assign bus.imem_req_o    = w_req;
  assign bus.imem_addr_o   = r_fetch_pc;
  assign bus.instr_valid_o = w_valid;
  assign bus.instr_o       = r_instr_mem[r_rd_ptr];
  assign bus.pc_o          = r_pc_mem[r_rd_ptr];
  assign bus.count_o       = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (bus.redirect_i) begin
      // Everything still outstanding after this cycle belongs to the old path.
      r_fetch_pc <= bus.redirect_pc_i;
      r_resp_pc  <= bus.redirect_pc_i;
      r_inflight <= r_inflight - CNT_W'(w_resp);
      r_drop     <= r_inflight - CNT_W'(w_resp);
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_issue) r_fetch_pc <= r_fetch_pc + STEP;
      if (w_drop_resp) r_drop <= r_drop - CNT_W'(1);
      if (w_push) begin
        r_resp_pc <= r_resp_pc + STEP;
        r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_resp);
      r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // NOTE: queue storage has no reset; r_count gates every read, so stale contents are
  // never observed and the array can map onto plain RAM/flops without reset wiring.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= bus.imem_rdata_i;
      r_pc_mem[r_wr_ptr]    <= r_resp_pc;
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  assert property (@(posedge clk_i) disable iff (rst_i)
    bus.imem_rvalid_i |-> (r_inflight != '0));

endmodule
